// File: rtl/pipe_pkg.sv
// Shared opcode constants and operand-usage decode for the issue controller.
package pipe_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;
  localparam logic [3:0] OP_LDR = 4'd13;
  localparam logic [3:0] OP_STR = 4'd14;
  localparam logic [3:0] OP_NOP = 4'd15;

  localparam logic [15:0] NOP_INSTR = 16'hF000;

  function automatic logic reads_ra(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
  endfunction

  // STR reads only the data register rb; LDR, NOP and undefined ops read nothing.
  function automatic logic reads_rb(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_STR};
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return !(op inside {OP_STR, OP_NOP});
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction buffer: power-of-two circular FIFO with synchronous flush.
module issue_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          din,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_W-1:0]          head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  assign head = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pipe_issue_ctl.sv
// In-order issue stage: buffers instructions and inserts NOP bubbles on RAW hazards
// against the two most recently issued instructions.
module pipe_issue_ctl
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  input  logic             hold,
  input  logic             flush,
  output logic [15:0]      instr,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic [15:0]   head;
  logic          push;
  logic          pop;
  logic          empty;
  logic          hazard;
  logic          issue;
  logic          stall_nxt;
  logic [3:0]    op;
  logic [3:0]    ra;
  logic [3:0]    rb;
  logic [3:0]    rd;

  // Scoreboard slots: _p0 issued at the last edge, _p1 at the edge before.
  logic          sb_vld_p0;
  logic          sb_vld_p1;
  logic [3:0]    sb_rd_p0;
  logic [3:0]    sb_rd_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic sb_hit(input logic [3:0] r, input logic v0, input logic [3:0] d0,
                                  input logic v1, input logic [3:0] d1);
    return (v0 && (d0 == r)) || (v1 && (d1 == r));
  endfunction

  issue_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (in_instr),
    .count (count),
    .head  (head)
  );

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign empty    = (count == '0);
  assign {op, ra, rb, rd} = head;

  always_comb begin
    hazard    = (reads_ra(op) && sb_hit(ra, sb_vld_p0, sb_rd_p0, sb_vld_p1, sb_rd_p1)) ||
                (reads_rb(op) && sb_hit(rb, sb_vld_p0, sb_rd_p0, sb_vld_p1, sb_rd_p1));
    issue     = !empty && !hold && !flush && !hazard;
    stall_nxt = !empty && !hold && !flush && hazard;
  end

  assign pop = issue;

  // Issue boundary: output register and scoreboard shift (flush does not clear it).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr      <= NOP_INSTR;
      stall      <= 1'b0;
      bubble_cnt <= '0;
      sb_vld_p0  <= 1'b0;
      sb_vld_p1  <= 1'b0;
    end else begin
      instr     <= issue ? head : NOP_INSTR;
      stall     <= stall_nxt;
      if (stall_nxt) bubble_cnt <= sat_inc(bubble_cnt);
      sb_vld_p0 <= issue && writes_rd(op);
      sb_vld_p1 <= sb_vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    sb_rd_p0 <= rd;
    sb_rd_p1 <= sb_rd_p0;
  end

endmodule

// File: tb/tb_pipe_issue_ctl.sv
// Bench for pipe_issue_ctl: directed vector table, multi-cycle corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pipe_issue_ctl;

  localparam int DEPTH = 4;
  localparam logic [15:0] NOP = 16'hF000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        hold;
  logic        flush;
  logic        in_ready, in_ready2;
  logic [15:0] instr, instr2;
  logic        stall, stall2;
  logic [15:0] bubble_cnt;
  logic [2:0]  bubble_cnt2;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  pipe_issue_ctl #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .hold(hold), .flush(flush), .instr(instr), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  pipe_issue_ctl #(.DEPTH(DEPTH), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready2),
    .hold(hold), .flush(flush), .instr(instr2), .stall(stall2), .bubble_cnt(bubble_cnt2)
  );

  // ---------------- reference model ----------------
  logic [15:0] mq[$];
  logic [15:0] mh0, mh1;
  int          mbub;
  logic [15:0] m_instr;
  logic        m_stall;

  function automatic bit m_reads_a(logic [3:0] op);
    return op == 0 || op == 1 || op == 2 || op == 6 || op == 7 || op == 12;
  endfunction
  function automatic bit m_reads_b(logic [3:0] op);
    return m_reads_a(op) || op == 14;
  endfunction
  function automatic bit m_writes(logic [3:0] op);
    return op != 14 && op != 15;
  endfunction
  function automatic bit depends(logic [15:0] c, logic [15:0] p);
    if (!m_writes(p[15:12])) return 0;
    return (m_reads_a(c[15:12]) && c[11:8] == p[3:0]) ||
           (m_reads_b(c[15:12]) && c[7:4] == p[3:0]);
  endfunction

  task automatic model_reset();
    mq.delete();
    mh0 = NOP; mh1 = NOP; mbub = 0; m_instr = NOP; m_stall = 0;
  endtask

  task automatic model_step(input logic v, input logic h, input logic f, input logic [15:0] d);
    logic [15:0] hd;
    bit hz, iss, rdy, nonempty;
    rdy = mq.size() < DEPTH;
    nonempty = mq.size() > 0;
    hd = nonempty ? mq[0] : NOP;
    hz = nonempty && (depends(hd, mh0) || depends(hd, mh1));
    iss = nonempty && !h && !f && !hz;
    m_stall = nonempty && !h && !f && hz;
    m_instr = iss ? hd : NOP;
    if (m_stall) mbub++;
    if (f) mq.delete();
    else begin
      if (iss) void'(mq.pop_front());
      if (v && rdy) mq.push_back(d);
    end
    mh1 = mh0; mh0 = m_instr;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic v, input logic h, input logic f, input logic [15:0] d);
    int e16, e3;
    in_valid = v; hold = h; flush = f; in_instr = d;
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    model_step(v, h, f, d);
    @(posedge clk); #1;
    e16 = (mbub > 65535) ? 65535 : mbub;
    e3  = (mbub > 7) ? 7 : mbub;
    check("instr", 32'(instr), 32'(m_instr));
    check("stall", 32'(stall), 32'(m_stall));
    check("bubble_cnt", 32'(bubble_cnt), 32'(e16));
    check("instr_sat_inst", 32'(instr2), 32'(m_instr));
    check("bubble_cnt_sat", 32'(bubble_cnt2), 32'(e3));
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [15:0] ei;
    logic        es;
    int          eb;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic v, logic [15:0] d, logic [15:0] ei, logic es, int eb);
    vec_t r;
    r.v = v; r.d = d; r.ei = ei; r.es = es; r.eb = eb;
    return r;
  endfunction

  logic [15:0] exp_order[4];

  initial begin
    // dependent pair, independent stream, LDR/STR pairs
    tbl[0]  = mk(1, 16'h2231, NOP,      0, 0);
    tbl[1]  = mk(1, 16'h6154, 16'h2231, 0, 0);
    tbl[2]  = mk(0, 16'h0000, NOP,      1, 1);
    tbl[3]  = mk(0, 16'h0000, NOP,      1, 2);
    tbl[4]  = mk(0, 16'h0000, 16'h6154, 0, 2);
    tbl[5]  = mk(0, 16'h0000, NOP,      0, 2);
    tbl[6]  = mk(1, 16'h2231, NOP,      0, 2);
    tbl[7]  = mk(1, 16'h0452, 16'h2231, 0, 2);
    tbl[8]  = mk(1, 16'h1673, 16'h0452, 0, 2);
    tbl[9]  = mk(0, 16'h0000, 16'h1673, 0, 2);
    tbl[10] = mk(0, 16'h0000, NOP,      0, 2);
    tbl[11] = mk(1, 16'hD001, NOP,      0, 2);
    tbl[12] = mk(1, 16'hE012, 16'hD001, 0, 2);
    tbl[13] = mk(0, 16'h0000, NOP,      1, 3);
    tbl[14] = mk(0, 16'h0000, NOP,      1, 4);
    tbl[15] = mk(0, 16'h0000, 16'hE012, 0, 4);
    tbl[16] = mk(1, 16'hD001, NOP,      0, 4);
    tbl[17] = mk(1, 16'h2230, 16'hD001, 0, 4);
    tbl[18] = mk(0, 16'h0000, 16'h2230, 0, 4);
    tbl[19] = mk(0, 16'h0000, NOP,      0, 4);

    rst = 1'b0; in_valid = 0; hold = 0; flush = 0; in_instr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", 32'(instr), 32'(NOP));
    check("rst_stall", 32'(stall), 0);
    check("rst_bubble", 32'(bubble_cnt), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].v, 1'b0, 1'b0, tbl[i].d);
      check("tbl_instr", 32'(instr), 32'(tbl[i].ei));
      check("tbl_stall", 32'(stall), 32'(tbl[i].es));
      check("tbl_bubble", 32'(bubble_cnt), 32'(tbl[i].eb));
    end

    // Fill under hold, fifth offer held off, then drain in order.
    exp_order[0] = 16'h2123; exp_order[1] = 16'h2456;
    exp_order[2] = 16'h2789; exp_order[3] = 16'h2ABC;
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, exp_order[i]);
    check("full_in_ready", 32'(in_ready), 0);
    cycle(1, 1, 0, 16'h2DEF);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 16'h0000);
      check("drain_order", 32'(instr), 32'(exp_order[i]));
      if (i == 0) check("ready_after_pop", 32'(in_ready), 1);
    end
    cycle(0, 0, 0, 16'h0000);
    check("no_fifth", 32'(instr), 32'(NOP));

    // Flush with 3 buffered and a simultaneous push; scoreboard keeps the writer.
    cycle(1, 1, 0, 16'h2711);
    cycle(1, 1, 0, 16'h0AAA);
    cycle(1, 1, 0, 16'h0BBB);
    cycle(1, 1, 0, 16'h0CCC);
    cycle(0, 0, 0, 16'h0000);
    check("pre_flush_issue", 32'(instr), 32'h2711);
    cycle(1, 0, 1, 16'h0DDD);
    check("flush_instr", 32'(instr), 32'(NOP));
    check("flush_stall", 32'(stall), 0);
    check("flush_ready", 32'(in_ready), 1);
    check("flush_sb_vld", 32'(dut.sb_vld_p1), 1);
    check("flush_sb_rd", 32'(dut.sb_rd_p1), 1);
    cycle(0, 1, 1, 16'h0000);
    check("hold_flush_instr", 32'(instr), 32'(NOP));
    cycle(0, 0, 0, 16'h0000);
    check("push_dropped", 32'(instr), 32'(NOP));

    // Asynchronous reset mid-stream with two buffered.
    cycle(1, 1, 0, 16'h2111);
    cycle(1, 1, 0, 16'h2222);
    rst = 1'b0;
    #1;
    check("arst_instr", 32'(instr), 32'(NOP));
    check("arst_bubble", 32'(bubble_cnt), 0);
    check("arst_ready", 32'(in_ready), 1);
    check("arst_stall", 32'(stall), 0);
    in_valid = 0; hold = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    cycle(0, 0, 0, 16'h0000);
    check("post_rst_empty", 32'(instr), 32'(NOP));
    cycle(0, 0, 0, 16'h0000);

    // Self-dependent chain drives the narrow counter into saturation.
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 16'h2111);
    for (int i = 0; i < 24; i++) cycle(0, 0, 0, 16'h0000);
    check("sat_value", 32'(bubble_cnt2), 7);

    // Randomized traffic with a small register space to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = {4'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      cycle(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 32) == 0, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
